// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle mult/div/madd/msub unit owning the HI/LO registers, with a busy window for hazard stalls.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MulOpE,
    input  logic [1:0]  MTHILOE,
    input  logic [1:0]  MFHILOE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        ExcFlush,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HILOOutE
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    logic [31:0] hi, lo, ua, ub, q, r, sq, sr;
    logic [63:0] pend, res, prod, hilo;
    logic [CW-1:0] cnt;
    logic busy, valid, is_div, is_sdiv, mul_s;
    assign valid = (MulOpE >= 4'd1) && (MulOpE <= 4'd8);
    assign is_div = (MulOpE == 4'd3) || (MulOpE == 4'd4);
    assign is_sdiv = MulOpE == 4'd3;
    assign mul_s = (MulOpE == 4'd1) || (MulOpE == 4'd5) || (MulOpE == 4'd7);
    assign Start = valid && !busy && !ExcFlush;
    assign Busy = busy;
    assign hilo = {hi, lo};
    assign HILOOutE = (MFHILOE == 2'b01) ? hi : (MFHILOE == 2'b10) ? lo : 32'd0;
    // Signed divide works on magnitudes, so 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    always_comb begin
        prod = mul_s ? {{32{SrcAE[31]}}, SrcAE} * {{32{SrcBE[31]}}, SrcBE} : {32'd0, SrcAE} * {32'd0, SrcBE};
        ua = (is_sdiv && SrcAE[31]) ? -SrcAE : SrcAE;
        ub = (is_sdiv && SrcBE[31]) ? -SrcBE : SrcBE;
        q = (ub == 32'd0) ? 32'd0 : ua / ub;
        r = (ub == 32'd0) ? 32'd0 : ua % ub;
        sq = (is_sdiv && (SrcAE[31] ^ SrcBE[31])) ? -q : q;
        sr = (is_sdiv && SrcAE[31]) ? -r : r;
        res = (MulOpE == 4'd1 || MulOpE == 4'd2) ? prod :
              (MulOpE == 4'd5 || MulOpE == 4'd6) ? hilo + prod :
              (MulOpE == 4'd7 || MulOpE == 4'd8) ? hilo - prod :
              (SrcBE == 32'd0) ? hilo : {sr, sq};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            pend <= '0;
            cnt <= '0;
            busy <= 1'b0;
        end else if (Start) begin
            cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            pend <= res;
            busy <= 1'b1;
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            busy <= cnt != CW'(1);
            if (cnt == CW'(1)) {hi, lo} <= pend;
        end else if (!ExcFlush) begin
            if (MTHILOE == 2'b01) hi <= SrcAE;
            if (MTHILOE == 2'b10) lo <= SrcAE;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors against a behavioural HI/LO model plus hand-computed literals.
module tb_mul_div_unit;
    localparam int MUL = 5;
    localparam int DIV = 10;
    logic clk = 0, reset = 1, ExcFlush = 0;
    logic [3:0] MulOpE = 0;
    logic [1:0] MTHILOE = 0, MFHILOE = 0;
    logic [31:0] SrcAE = 0, SrcBE = 0, HILOOutE;
    logic Start, Busy;
    int checks = 0, errors = 0;
    mul_div_unit #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(reset), .MulOpE(MulOpE), .MTHILOE(MTHILOE), .MFHILOE(MFHILOE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ExcFlush(ExcFlush),
        .Start(Start), .Busy(Busy), .HILOOutE(HILOOutE));
    always #5 clk = ~clk;
    logic [31:0] mhi, mlo;
    logic [63:0] mpend;
    logic mdz, started = 0;
    int rem = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [63:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] hl);
        int sa, sb;
        longint sp;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        sp = longint'(sa) * longint'(sb);
        up = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1: return sp;
            4'd2: return up;
            4'd5: return hl + sp;
            4'd6: return hl + up;
            4'd7: return hl - sp;
            4'd8: return hl - up;
            4'd3: begin
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: return {a % b, a / b};
        endcase
    endfunction
    function automatic logic is_valid(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd8;
    endfunction
    always @(posedge clk) begin
        if (reset) begin
            mhi = 0;
            mlo = 0;
            rem = 0;
            started = 1;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0 && !mdz) {mhi, mlo} = mpend;
        end else if (is_valid(MulOpE) && !ExcFlush) begin
            rem = (MulOpE == 3 || MulOpE == 4) ? DIV : MUL;
            mdz = (MulOpE == 3 || MulOpE == 4) && SrcBE == 0;
            if (!mdz) mpend = model_res(MulOpE, SrcAE, SrcBE, {mhi, mlo});
        end else if (!ExcFlush) begin
            if (MTHILOE == 2'b01) mhi = SrcAE;
            if (MTHILOE == 2'b10) mlo = SrcAE;
        end
    end
    always @(negedge clk) begin
        if (started) begin
            chk("start", 64'(Start), 64'(is_valid(MulOpE) && rem == 0 && !ExcFlush));
            chk("busy", 64'(Busy), 64'(rem != 0));
            chk("hilo_out", 64'(HILOOutE), 64'((MFHILOE == 2'b01) ? mhi : (MFHILOE == 2'b10) ? mlo : 32'd0));
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MulOpE = op;
        SrcAE = a;
        SrcBE = b;
        step(1);
        MulOpE = 0;
    endtask
    task automatic mt(input logic [1:0] sel, input logic [31:0] a);
        MTHILOE = sel;
        SrcAE = a;
        step(1);
        MTHILOE = 0;
    endtask
    task automatic count_busy(input int n, output int nb);
        nb = 0;
        repeat (n) begin
            nb += int'(Busy);
            step(1);
        end
    endtask
    task automatic rd(input string name, input logic [1:0] sel, input logic [31:0] exp);
        MFHILOE = sel;
        #1;
        chk(name, 64'(HILOOutE), 64'(exp));
        MFHILOE = 0;
    endtask
    initial begin
        int nb;
        step(2);
        reset = 0;
        rd("reset_hi", 2'b01, 32'd0);
        rd("reset_lo", 2'b10, 32'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
        issue(4'd1, 32'hFFFFFFFB, 32'd3);
        count_busy(8, nb);
        chk("mult_busy_len", 64'(nb), 64'(MUL));
        rd("mult_hi", 2'b01, 32'hFFFFFFFF);
        rd("mult_lo", 2'b10, 32'hFFFFFFF1);
        chk("model_mult", {mhi, mlo}, 64'hFFFFFFFF_FFFFFFF1);
        rd("mf_none", 2'b11, 32'd0);
        issue(4'd3, 32'd7, 32'hFFFFFFFE);
        issue(4'd1, 32'd100, 32'd100);
        count_busy(12, nb);
        chk("div_busy_len", 64'(nb + 1), 64'(DIV));
        rd("div_lo", 2'b10, 32'hFFFFFFFD);
        rd("div_hi", 2'b01, 32'd1);
        mt(2'b01, 32'h11);
        mt(2'b10, 32'h22);
        issue(4'd4, 32'd9, 32'd0);
        count_busy(12, nb);
        chk("divz_busy_len", 64'(nb), 64'(DIV));
        rd("divz_hi", 2'b01, 32'h11);
        rd("divz_lo", 2'b10, 32'h22);
        mt(2'b01, 32'hDEADBEEF);
        rd("mthi_hi", 2'b01, 32'hDEADBEEF);
        rd("mthi_lo", 2'b10, 32'h22);
        mt(2'b10, 32'd0);
        issue(4'd5, 32'd2, 32'd3);
        step(MUL);
        rd("madd_hi", 2'b01, 32'hDEADBEEF);
        rd("madd_lo", 2'b10, 32'd6);
        chk("model_madd", {mhi, mlo}, 64'hDEADBEEF_00000006);
        issue(4'd7, 32'd2, 32'd3);
        step(MUL);
        rd("msub_lo", 2'b10, 32'd0);
        MulOpE = 4'd2;
        SrcAE = 32'd5;
        SrcBE = 32'd5;
        ExcFlush = 1;
        #1;
        chk("flush_start", 64'(Start), 64'd0);
        step(1);
        MulOpE = 0;
        chk("flush_busy", 64'(Busy), 64'd0);
        MTHILOE = 2'b10;
        SrcAE = 32'h1234;
        step(1);
        MTHILOE = 0;
        ExcFlush = 0;
        rd("flush_mtlo", 2'b10, 32'd0);
        rd("flush_hi", 2'b01, 32'hDEADBEEF);
        issue(4'd1, 32'd7, 32'd9);
        step(2);
        reset = 1;
        step(1);
        reset = 0;
        chk("rst_mid_busy", 64'(Busy), 64'd0);
        rd("rst_mid_hi", 2'b01, 32'd0);
        step(8);
        rd("rst_nocommit_lo", 2'b10, 32'd0);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        step(DIV);
        rd("ovf_lo", 2'b10, 32'h80000000);
        rd("ovf_hi", 2'b01, 32'd0);
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step(MUL);
        chk("b2b_busy_low", 64'(Busy), 64'd0);
        chk("model_multu", {mhi, mlo}, 64'hFFFFFFFE_00000001);
        MulOpE = 4'd6;
        SrcAE = 32'hFFFFFFFF;
        SrcBE = 32'd2;
        #1;
        chk("b2b_start", 64'(Start), 64'd1);
        step(1);
        MulOpE = 0;
        step(MUL);
        rd("maddu_hi", 2'b01, 32'hFFFFFFFF);
        rd("maddu_lo", 2'b10, 32'hFFFFFFFF);
        issue(4'd8, 32'd3, 32'd4);
        step(MUL);
        rd("msubu_lo", 2'b10, 32'hFFFFFFF3);
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        step(DIV);
        rd("sdiv_lo", 2'b10, 32'hFFFFFFFD);
        rd("sdiv_hi", 2'b01, 32'hFFFFFFFF);
        issue(4'd9, 32'd1, 32'd1);
        chk("op9_busy", 64'(Busy), 64'd0);
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit in the EX stage, owning the HI/LO architectural registers. It consumes the HI/LO control fields that the ID/EX pipeline register delivers: MulOpE, MTHILOE and MFHILOE. It raises Start/Busy so the hazard unit can stall and hold the ID/EX register (en) while an operation is in flight. It returns HI or LO for mfhi/mflo instructions in EX.

## Interface
- MUL_CYCLES, 5: busy cycles for mult/multu/madd/maddu/msub/msubu (≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥1).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- MulOpE  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu; 9–15 behave as none.
- MTHILOE  input  2  01 mthi, 10 mtlo, else none.
- MFHILOE  input  2  01 select HI, 10 select LO, else output 0.
- SrcAE  input  32  forwarded rs operand.
- SrcBE  input  32  forwarded rt operand.
- ExcFlush  input  1  exception/eret flush from M; suppresses any start or MT write in this cycle.
- Start  output  1  combinational: valid op (1–8) && !Busy && !ExcFlush.
- Busy  output  1  registered: operation in flight.
- HILOOutE  output  32  combinational HI/LO read per MFHILOE.

## Operation
- State:
  - HI, LO (32 each).
  - Pending result {PHI, PLO} (64).
  - Down-counter cnt (wide enough for max(MUL_CYCLES, DIV_CYCLES)).
  - Busy = (cnt != 0), held as a register.
- States:
  - IDLE (cnt==0): Start loads cnt with MUL_CYCLES or DIV_CYCLES and loads the pending result. Busy goes high next cycle.
  - RUN (cnt!=0): cnt decrements each cycle. When cnt==1, HI←PHI and LO←PLO, and cnt becomes 0 (IDLE).
- Pending result, computed at Start from SrcAE/SrcBE:
  - mult: signed 64-bit product.
  - multu: unsigned 64-bit product.
  - madd/maddu: {HI,LO} + product, wrapping mod 2^64.
  - msub/msubu: {HI,LO} − product, wrapping mod 2^64.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / −1: LO=0x80000000, HI=0.
  - Divide by zero: the op still runs DIV_CYCLES, but HI/LO are left unchanged at commit.
- The implementation may be combinational at Start or iterative across the busy window. Only the commit cycle is architecturally visible.
- MT writes:
  - MTHILOE=01 writes HI←SrcAE; MTHILOE=10 writes LO←SrcAE. Both take effect at the clock edge.
  - Suppressed when ExcFlush or Busy is high.
- A valid MulOpE arriving while Busy is ignored (no restart, no cancel). The hazard unit guarantees this never happens architecturally.
- ExcFlush does not cancel an in-flight operation; it completes and commits.
- MFHILOE during Busy returns the old HI/LO. The hazard unit stalls mf instructions while Start||Busy.
- Reset:
  - HI=LO=0, PHI=PLO=0, cnt=0, Busy=0.
  - A reset mid-operation aborts it with no commit.
  - Start and HILOOutE follow their inputs combinationally.

## Timing
- Start of an op of length L is asserted in cycle N.
- Busy is high in cycles N+1 … N+L.
- HI/LO update at the edge ending cycle N+L. An mfhi in EX during N+L+1 sees the new value.
- Busy falls in cycle N+L+1, so a new op may start in N+L+1 (back-to-back).
- An MT write in cycle N is visible on HILOOutE in N+1.
- Start and MT in the same cycle cannot occur: one instruction carries one field.
- Simultaneous ExcFlush and valid MulOpE: Start=0, cnt stays 0, nothing changes.

## Test plan
- mult with SrcAE=0xFFFFFFFB (−5), SrcBE=3 → Busy high 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFF1; mfhi returns 0xFFFFFFFF.
- div 7 / −2 → Busy 10 cycles, LO=0xFFFFFFFD (−3), HI=1. A second op issued during Busy is ignored.
- divu with HI/LO preset to 0x11/0x22 and SrcBE=0 → Busy 10 cycles, HI=0x11 and LO=0x22 unchanged.
- mthi 0xDEADBEEF, then mflo/mfhi → HI=0xDEADBEEF next cycle, LO unchanged. Then madd 2×3 → {HI,LO} = 0xDEADBEEF_00000006 (LO preset 0).
- multu with ExcFlush=1 in the same cycle → Start=0, Busy stays 0, HI/LO unchanged. mtlo with ExcFlush=1 is also suppressed.
- Start mult, assert reset on the 3rd busy cycle → next cycle Busy=0, HI=LO=0, no later commit.
